// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module : muldiv_unit_pkg
//  Brief  : Op codes and FSM state encodings for the iterative mul/div unit
//  Rev    : 1.0  initial release
// ============================================================================
package muldiv_unit_pkg;

  // Operation codes carried on the op port
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage : muldiv_unit_pkg
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module : muldiv_unit
//  Brief  : Iterative WIDTH-bit multiply/divide unit with HI/LO registers.
//           Shift-add multiply, restoring divide, WIDTH iterations plus one
//           sign-fix cycle; fixed latency regardless of operand values.
//  Rev    : 1.0  initial release
// ============================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // {upper, lower}: product or {rem, quo}
  logic [WIDTH-1:0]     opb_q, opb_d;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0]     dvd_q, dvd_d;      // raw dividend, returned on divide by zero
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;      // product / quotient must be negated
  logic                 rem_neg_q, rem_neg_d;
  logic                 dz_q, dz_d;        // divisor was zero
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  // Operand decode at accept time
  logic             is_md_op;
  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_md_op  = (op == MD_MULT) || (op == MD_MULTU) ||
                     (op == MD_DIV)  || (op == MD_DIVU);
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? (~a + 1'b1) : a;
  assign b_mag     = b_neg ? (~b + 1'b1) : b;

  // One shift-add multiply step: multiplier sits in the low half and is
  // consumed LSB-first while the partial product shifts in from the top.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step: shift {rem, quo} left, trial-subtract the
  // divisor from the widened remainder, keep it only if it did not borrow.
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     div_sub;
  logic [2*WIDTH-1:0]   div_next;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_sub  = {1'b0, rem_sh} - {2'b00, opb_q};
  assign div_next = div_sub[WIDTH+1]
                    ? {rem_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0}
                    : {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign-corrected results used in the fix cycle
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;
  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_raw  = acc_q[WIDTH-1:0];
  assign rem_raw  = acc_q[2*WIDTH-1:WIDTH];
  assign quo_fix  = neg_q     ? (~quo_raw + 1'b1) : quo_raw;
  assign rem_fix  = rem_neg_q ? (~rem_raw + 1'b1) : rem_raw;

  // Next-state, datapath and HI/LO update logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    dvd_d     = dvd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end else if (is_md_op) begin
            is_div_d  = op[1];
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            dz_d      = (b == {WIDTH{1'b0}});
            dvd_d     = a;
            cnt_d     = '0;
            if (op[1]) begin
              acc_d = {{WIDTH{1'b0}}, a_mag};
              opb_d = b_mag;
            end else begin
              acc_d = {{WIDTH{1'b0}}, b_mag};
              opb_d = a_mag;
            end
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = dvd_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      dvd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      dvd_q     <= dvd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module : tb_muldiv_unit
//  Brief  : Self-checking bench for muldiv_unit: vector table plus random
//           vectors through a result scoreboard, and hand-written sequences
//           for MTHI/MTLO, ignored starts and asynchronous reset.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  res_t sb_q[$];
  vec_t tbl[9];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference results using native SystemVerilog arithmetic
  function automatic res_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t    r;
    longint  sx, sy, p;
    logic [63:0] up;
    int      xs, ys, q, m;
    r = '0;
    case (o)
      3'd0: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sx * sy;
        r  = p;
      end
      3'd1: begin
        up = {32'd0, x} * {32'd0, y};
        r  = up;
      end
      3'd2: begin
        if (y == 32'd0)                                  r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin
          xs = x; ys = y;
          q = xs / ys;
          m = xs % ys;
          r = {m, q};
        end
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else            r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // Drive a start at the current falling edge; returns one cycle after accept
  task automatic drive_start(input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, input res_t exp);
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    chk("done_low_after_accept", {63'd0, done}, 64'd0);
  endtask

  // Wait for done (bounded), check latency and compare against the scoreboard
  task automatic wait_result(input string nm, input int elapsed);
    int   k;
    bit   got;
    res_t exp;
    got = 1'b0;
    k   = elapsed;
    while (!got && k < 45) begin
      @(negedge clk);
      k++;
      if (done) got = 1'b1;
    end
    chk({nm, "_latency"}, 64'(k), 64'd33);
    if (!got) begin
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      return;
    end
    chk({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    if (sb_q.size() == 0) begin
      chk({nm, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      chk({nm, "_hi"}, {32'd0, hi}, {32'd0, exp.hi});
      chk({nm, "_lo"}, {32'd0, lo}, {32'd0, exp.lo});
    end
  endtask

  initial begin
    res_t e;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    tbl[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14};
    tbl[3] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    tbl[5] = '{3'd2, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
    tbl[6] = '{3'd3, 32'hFFFF_FFFF, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
    tbl[8] = '{3'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};

    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table, issued back-to-back (next start on the done cycle)
    for (int i = 0; i < 9; i++) begin
      drive_start(tbl[i].op, tbl[i].a, tbl[i].b, '{tbl[i].hi, tbl[i].lo});
      wait_result($sformatf("tbl%0d", i), 0);
    end

    // Random vectors against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      drive_start(ro, ra, rb, model(ro, ra, rb));
      wait_result($sformatf("rnd%0d_op%0d", i, ro), 0);
    end
    @(negedge clk);
    chk("done_drops", {63'd0, done}, 64'd0);

    // Idle MTLO / MTHI: single-edge write, no busy or done
    start = 1'b1; op = 3'd5; a = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", {32'd0, lo}, 64'h1234);
    chk("mtlo_busy_done", {62'd0, busy, done}, 64'd0);
    start = 1'b1; op = 3'd4; a = 32'hAAAA_0000;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_hi", {32'd0, hi}, 64'hAAAA_0000);
    chk("mthi_busy_done", {62'd0, busy, done}, 64'd0);

    // Reserved op is ignored
    start = 1'b1; op = 3'd6; a = 32'h5555_5555; b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("reserved_busy", {63'd0, busy}, 64'd0);
    chk("reserved_hilo", {hi, lo}, {32'hAAAA_0000, 32'h0000_1234});

    // Starts while busy are ignored; old HI/LO stay readable during RUN
    e = '{32'd0, 32'd15};
    drive_start(3'd0, 32'd3, 32'd5, e);
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(negedge clk);
    op = 3'd2; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("run_hilo_held", {hi, lo}, {32'hAAAA_0000, 32'h0000_1234});
    wait_result("ignore_busy", 2);
    repeat (3) @(negedge clk);
    chk("ignore_no_restart", {63'd0, busy}, 64'd0);
    chk("ignore_hilo_kept", {hi, lo}, 64'd15);

    // Asynchronous reset in the middle of RUN
    drive_start(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {63'd0, busy}, 64'd0);
    chk("async_rst_done", {63'd0, done}, 64'd0);
    chk("async_rst_hilo", {hi, lo}, 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {63'd0, busy}, 64'd0);
    drive_start(3'd0, 32'd6, 32'd7, '{32'd0, 32'd42});
    wait_result("mult_6x7", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_muldiv_unit
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the Antares-R2 core.
- Sits in the execute stage, beside the ALU.
- Its hi/lo outputs feed the 4:1 32-bit writeback/result mux (inputs C and D) for MFHI/MFLO.
- Hazard control stalls on busy.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous, active-high reset
start  input   1      request; sampled on rising clk edge
op     input   3      operation code (see package)
a      input   32     rs operand (dividend / multiplicand / MTHI-MTLO data)
b      input   32     rt operand (divisor / multiplier)
busy   output  1      operation in progress; new start ignored
done   output  1      one-cycle pulse: hi/lo just updated by MULT/DIV
hi     output  32     HI register
lo     output  32     LO register

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - state=IDLE.
  - busy=0, done=0, hi=0, lo=0.
  - Iteration counter and internal accumulators cleared.
  - An in-flight operation is discarded.
- Op encoding:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - 6 and 7 are reserved: start with these is ignored, no state change.
- States: IDLE, RUN, FIX.
- IDLE:
  - start with op MTHI: hi<=a at that edge. busy stays 0, done stays 0.
  - start with op MTLO: lo<=a at that edge. busy stays 0, done stays 0.
  - start with op 0-3 (edge E0):
    - Latch operand magnitudes (abs for signed ops), result-sign flags, op class.
    - Clear the counter. Go to RUN. busy=1 from E0.
- RUN: one iteration per cycle for edges E1..E32. Counter 0..31; leave for FIX when counter reaches 31.
  - Multiply: shift-add on a 64-bit product register, LSB-first on the multiplier.
  - Divide: restoring shift-subtract. Remainder in the upper half, quotient in the lower half.
- FIX (edge E33):
  - Apply sign correction.
  - Write hi/lo. State returns to IDLE.
  - busy=0 and done=1 after E33; done drops after E34.
  - hi/lo are stable and valid from E33.
- Latency: accept edge to result edge = 33 cycles, independent of operand values.
- Sign rules:
  - MULT: 64-bit product negated if signs differ.
  - DIV: quotient (lo) negative if signs differ; remainder (hi) takes the dividend's sign.
- Divide by zero (DIV or DIVU, b=0):
  - Fixed latency is kept.
  - Result hi=a (unmodified dividend), lo=32'hFFFFFFFF.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps naturally).
- start while busy=1: ignored, including MTHI/MTLO. The upstream stall prevents this; the unit must still be robust to it.
- start at E34 (cycle after done): accepted normally. Back-to-back operations are allowed.
- hi/lo hold their values during RUN (old values remain readable). Only FIX, MTHI or MTLO modify them.

Decomposition:
- Shared package/include (guarded define) holds:
  - op codes MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO;
  - state encodings S_IDLE, S_RUN, S_FIX.
- No sub-module needed: a single FSM plus datapath in one module. An optional helper, abs32, is purely combinational.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=7:
   - busy high from the accept edge; done pulse 33 cycles later.
   - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. MULTU a=b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
   Then back-to-back DIVU a=100, b=7: lo=14, hi=2, accepted the cycle after done.
3. DIV a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
   DIV a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
4. DIV a=5, b=0: after 33 cycles hi=0x00000005, lo=0xFFFFFFFF, done=1.
5. Idle MTLO a=0x1234: lo=0x1234 next edge, busy/done stay 0.
   During a running MULT, issue MTHI and DIV starts: both ignored, and the MULT result is unchanged.
6. Reset handling:
   - Assert rst asynchronously at RUN iteration 10: busy, done, hi, lo go 0 immediately without a clock edge.
   - After release, a new MULT 6*7 gives lo=42, hi=0.
